// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the fast-monitoring spy-buffer readout engine.
package fm_sb_pkg;

    localparam int FM_SB_N      = 29;
    localparam int FM_AW        = 16;
    localparam int FM_DW        = 32;
    localparam int FM_SBW       = $clog2(FM_SB_N);
    localparam int FM_RD_SETTLE = 4;
    localparam int FM_RD_DEPTH  = 8;

    typedef enum logic [2:0] {
        FM_RD_IDLE     = 3'd0,
        FM_RD_FRZ_WAIT = 3'd1,
        FM_RD_READ     = 3'd2,
        FM_RD_DRAIN    = 3'd3,
        FM_RD_HOLD     = 3'd4
    } fm_rd_state_t;

    // One entry of the output stream as it sits in the readout FIFO.
    typedef struct packed {
        logic [FM_DW-1:0]  data;
        logic [FM_SBW-1:0] sb;
        logic              last;
    } fm_stream_word_t;

    // HOLD keeps the freeze but is not considered busy.
    function automatic logic fm_rd_is_busy(input fm_rd_state_t s);
        return (s == FM_RD_FRZ_WAIT) || (s == FM_RD_READ) || (s == FM_RD_DRAIN);
    endfunction

endpackage

// File: rtl/fm_rd_fifo.sv
// First-word-fall-through FIFO with occupancy count, synchronous flush and
// synchronous active-high reset.
module fm_rd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_wr,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_rd,
    output logic [W-1:0]           o_rdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_V = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr    = i_wr && (r_count != FULL_V);
    assign w_rd    = i_rd && (r_count != {(PW+1){1'b0}});
    assign o_empty = (r_count == {(PW+1){1'b0}});
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush behaves like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fm_spy_reader.sv
// Spy-buffer readout engine: freezes one buffer, reads a programmed address
// window from it and streams the words out with valid/ready backpressure.
module fm_spy_reader
    import fm_sb_pkg::*;
#(
    parameter int SB_N   = FM_SB_N,
    parameter int AW     = FM_AW,
    parameter int DW     = FM_DW,
    parameter int SETTLE = FM_RD_SETTLE,
    parameter int DEPTH  = FM_RD_DEPTH
) (
    input  logic                    i_clk_hs,
    input  logic                    i_rst_hs,
    input  logic                    i_start,
    input  logic [$clog2(SB_N)-1:0] i_start_sb,
    input  logic [AW-1:0]           i_start_addr,
    input  logic [AW-1:0]           i_word_count,
    input  logic                    i_hold_freeze,
    input  logic                    i_release,
    input  logic                    i_abort,
    output logic [SB_N-1:0]         o_freeze,
    output logic [SB_N-1:0]         o_spy_en,
    output logic [AW-1:0]           o_spy_addr,
    input  logic [DW*SB_N-1:0]      i_spy_data,
    output logic [DW-1:0]           o_m_data,
    output logic [$clog2(SB_N)-1:0] o_m_sb,
    output logic                    o_m_valid,
    output logic                    o_m_last,
    input  logic                    i_m_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int SBW = $clog2(SB_N);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int STW = $clog2(SETTLE + 1);
    localparam logic [SBW-1:0] SB_MAX      = SBW'(SB_N - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE - 1);
    localparam logic [CW:0]    DEPTH_V     = (CW+1)'(DEPTH);

    fm_rd_state_t    r_state;
    fm_rd_state_t    w_state_nx;
    logic [SBW-1:0]  r_sb;
    logic [SBW-1:0]  w_sb_nx;
    logic [AW-1:0]   r_next_addr;
    logic [AW-1:0]   r_remaining;
    logic [AW-1:0]   r_spy_addr;
    logic            r_hold;
    logic            r_zero;
    logic [STW-1:0]  r_settle;
    logic            r_rd_act;
    logic            r_rd_last;
    logic            r_cap;
    logic            r_cap_last;
    logic [SB_N-1:0] r_spy_en;
    logic [SB_N-1:0] r_freeze;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_start_ok;
    logic            w_start_bad;
    logic            w_abort;
    logic            w_pop;
    logic            w_last_hs;
    logic            w_room;
    logic            w_issue;
    logic            w_done_nx;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic [CW:0]     w_cnt_nx;
    logic [DW-1:0]   w_spy_word [SB_N];
    fm_stream_word_t w_wr_word;
    fm_stream_word_t w_rd_word;

    function automatic logic [SB_N-1:0] f_onehot(input logic [SBW-1:0] idx);
        f_onehot = {{(SB_N-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar g = 0; g < SB_N; g++) begin : g_spy
        assign w_spy_word[g] = i_spy_data[g*DW +: DW];
    end

    assign w_start_ok  = (r_state == FM_RD_IDLE) && i_start && (i_start_sb <= SB_MAX);
    assign w_start_bad = (r_state == FM_RD_IDLE) && i_start && (i_start_sb > SB_MAX);
    assign w_abort     = i_abort && (r_state != FM_RD_IDLE);
    assign w_pop       = !w_fifo_empty && i_m_ready;
    assign w_last_hs   = w_pop && w_rd_word.last;
    assign w_sb_nx     = w_start_ok ? i_start_sb : r_sb;

    // Next-state selection and completion pulse.
    always_comb begin
        w_state_nx = r_state;
        w_done_nx  = 1'b0;
        case (r_state)
            FM_RD_IDLE: begin
                if (w_start_ok) w_state_nx = FM_RD_FRZ_WAIT;
                else            w_state_nx = FM_RD_IDLE;
            end
            FM_RD_FRZ_WAIT: begin
                if (w_abort)                       w_state_nx = FM_RD_IDLE;
                else if (r_settle == SETTLE_LAST)  w_state_nx = r_zero ? FM_RD_DRAIN : FM_RD_READ;
                else                               w_state_nx = FM_RD_FRZ_WAIT;
            end
            FM_RD_READ: begin
                if (w_abort)                          w_state_nx = FM_RD_IDLE;
                else if (r_remaining == {AW{1'b0}})   w_state_nx = FM_RD_DRAIN;
                else                                  w_state_nx = FM_RD_READ;
            end
            FM_RD_DRAIN: begin
                if (w_abort) begin
                    w_state_nx = FM_RD_IDLE;
                end else if (r_zero || w_last_hs) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = r_hold ? FM_RD_HOLD : FM_RD_IDLE;
                end else begin
                    w_state_nx = FM_RD_DRAIN;
                end
            end
            FM_RD_HOLD: begin
                if (w_abort || i_release) w_state_nx = FM_RD_IDLE;
                else                      w_state_nx = FM_RD_HOLD;
            end
            default: w_state_nx = FM_RD_IDLE;
        endcase
    end

    // A read is launched one cycle ahead, so room is judged on next-cycle
    // occupancy plus the read that is already in flight.
    assign w_cnt_nx = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_cap} - {{CW{1'b0}}, w_pop};
    assign w_room   = (w_cnt_nx + {{CW{1'b0}}, r_rd_act}) < DEPTH_V;
    assign w_issue  = (w_state_nx == FM_RD_READ) && (r_remaining != {AW{1'b0}}) && w_room;

    assign w_wr_word = '{data: w_spy_word[r_sb], sb: r_sb, last: r_cap_last};

    fm_rd_fifo #(
        .W     ($bits(fm_stream_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk_hs),
        .i_rst   (i_rst_hs),
        .i_flush (w_abort),
        .i_wr    (r_cap),
        .i_wdata (w_wr_word),
        .i_rd    (w_pop),
        .o_rdata (w_rd_word),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Transfer context, read pipeline and capture pipeline.
    always_ff @(posedge i_clk_hs) begin
        if (i_rst_hs) begin
            r_state     <= FM_RD_IDLE;
            r_sb        <= {SBW{1'b0}};
            r_next_addr <= {AW{1'b0}};
            r_remaining <= {AW{1'b0}};
            r_hold      <= 1'b0;
            r_zero      <= 1'b0;
            r_settle    <= {STW{1'b0}};
            r_rd_act    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_start_ok) begin
                r_sb        <= i_start_sb;
                r_next_addr <= i_start_addr;
                r_remaining <= i_word_count;
                r_hold      <= i_hold_freeze;
                r_zero      <= (i_word_count == {AW{1'b0}});
            end else if (w_issue) begin
                r_next_addr <= r_next_addr + AW'(1);
                r_remaining <= r_remaining - AW'(1);
            end
            r_settle   <= ((r_state == FM_RD_FRZ_WAIT) && (w_state_nx == FM_RD_FRZ_WAIT))
                          ? r_settle + STW'(1) : {STW{1'b0}};
            r_rd_act   <= w_issue;
            r_rd_last  <= w_issue && (r_remaining == AW'(1));
            r_cap      <= r_rd_act && !w_abort;
            r_cap_last <= r_rd_last;
        end
    end

    // Registered control outputs.
    always_ff @(posedge i_clk_hs) begin
        if (i_rst_hs) begin
            r_spy_en   <= {SB_N{1'b0}};
            r_spy_addr <= {AW{1'b0}};
            r_freeze   <= {SB_N{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_spy_en   <= w_issue ? f_onehot(r_sb) : {SB_N{1'b0}};
            r_spy_addr <= w_issue ? r_next_addr : {AW{1'b0}};
            r_freeze   <= (w_state_nx != FM_RD_IDLE) ? f_onehot(w_sb_nx) : {SB_N{1'b0}};
            r_busy     <= fm_rd_is_busy(w_state_nx);
            r_done     <= w_done_nx;
            r_err      <= w_start_bad;
        end
    end

    assign o_freeze   = r_freeze;
    assign o_spy_en   = r_spy_en;
    assign o_spy_addr = r_spy_addr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_m_valid  = !w_fifo_empty;
    assign o_m_data   = o_m_valid ? w_rd_word.data : {DW{1'b0}};
    assign o_m_sb     = o_m_valid ? w_rd_word.sb   : {SBW{1'b0}};
    assign o_m_last   = o_m_valid && w_rd_word.last;

endmodule
